alu_op_scheduler: RTL and testbench

Round-robin scheduler that shares the single 8-bit fixed-latency ALU pipeline (add / multiply / multiply-add) between NREQ on-chip requesters. It grants at most one operation per cycle, drives the ALU operand/select inputs, and tags each issued operation. It then routes the result back to the originating requester exactly LATENCY cycles after issue. It sits between the requester fabric and the ALU datapath and replaces direct bus writes to the ALU operand register.

---
 rtl/alu_sched_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/alu_op_scheduler.sv | 133 +++++++++++++
 tb/tb_alu_op_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared encodings and tag type for the ALU op scheduler
package alu_sched_pkg;

    localparam int ALU_LATENCY = 9;
    localparam int ID_W        = 3;

    typedef enum logic [1:0] {
        SEL_ADD     = 2'b00,
        SEL_MUL     = 2'b01,
        SEL_MAC     = 2'b10,
        SEL_ILLEGAL = 2'b11
    } alu_sel_e;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            err;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with pointer advanced on grant
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] last_q, last_d;
    logic          found;
    int            idx;

    // search from the requester after the last grant, first hit wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_q) + k) % N;
            if (!found && req[IW'(idx)]) begin
                found           = 1'b1;
                gnt[IW'(idx)]   = 1'b1;
                gnt_idx         = IW'(idx);
            end
        end
        last_d = advance ? gnt_idx : last_q;
    end

    // pointer resets to the last slot so requester 0 is searched first
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= IW'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// rtl/alu_op_scheduler.sv - shares one fixed-latency ALU between NREQ requesters
module alu_op_scheduler
    import alu_sched_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int LATENCY = ALU_LATENCY,
    parameter  int DW      = 8,
    localparam int IW      = $clog2(NREQ),
    localparam int CW      = $clog2(LATENCY + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hold,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    input  logic [NREQ*DW-1:0] req_m,
    input  logic [NREQ*2-1:0]  req_sel,
    output logic [DW-1:0]      alu_a,
    output logic [DW-1:0]      alu_b,
    output logic [DW-1:0]      alu_m,
    output logic [1:0]         alu_sel,
    output logic               alu_issue,
    input  logic [DW-1:0]      alu_out,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic               rsp_err,
    output logic [CW-1:0]      inflight,
    output logic               busy
);

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            granted;
    logic [1:0]      sel_in;

    logic [DW-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_m_q, alu_m_d;
    logic [1:0]    alu_sel_q, alu_sel_d;
    tag_t          issue_tag_q, issue_tag_d;
    tag_t          pipe_q [LATENCY];
    tag_t          pipe_d [LATENCY];
    tag_t          head;
    logic [CW-1:0] inflight_q, inflight_d;

    // no grants while held or in reset
    assign eligible  = req_valid & {NREQ{~(hold | reset)}};
    assign granted   = |gnt;
    assign req_ready = gnt;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (eligible),
        .advance (granted),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // capture the granted requester's operands; illegal ops issue as add but are tagged err
    always_comb begin
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_m_d     = alu_m_q;
        alu_sel_d   = alu_sel_q;
        issue_tag_d = '0;
        sel_in      = req_sel[gnt_idx*2 +: 2];
        if (granted) begin
            alu_a_d           = req_a[gnt_idx*DW +: DW];
            alu_b_d           = req_b[gnt_idx*DW +: DW];
            alu_m_d           = req_m[gnt_idx*DW +: DW];
            alu_sel_d         = (sel_in == SEL_ILLEGAL) ? SEL_ADD : sel_in;
            issue_tag_d.valid = 1'b1;
            issue_tag_d.id    = ID_W'(gnt_idx);
            issue_tag_d.err   = (sel_in == SEL_ILLEGAL);
        end
    end

    // tag pipe shifts every cycle so its head lines up with the ALU result;
    // inflight counts tags not yet at the head, so it peaks at LATENCY
    always_comb begin
        pipe_d[0] = issue_tag_q;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        inflight_d = inflight_q + CW'(issue_tag_d.valid) - CW'(pipe_q[LATENCY-2].valid);
    end

    // response decode from the pipe head
    always_comb begin
        head = pipe_q[LATENCY-1];
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = head.valid && !reset && (head.id == ID_W'(i));
        end
        rsp_err  = head.valid && !reset && head.err;
        rsp_data = (head.valid && !reset && !head.err) ? alu_out : '0;
    end

    // state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_m_q     <= '0;
            alu_sel_q   <= '0;
            issue_tag_q <= '0;
            inflight_q  <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_m_q     <= alu_m_d;
            alu_sel_q   <= alu_sel_d;
            issue_tag_q <= issue_tag_d;
            inflight_q  <= inflight_d;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_m     = alu_m_q;
    assign alu_sel   = alu_sel_q;
    assign alu_issue = issue_tag_q.valid;
    assign inflight  = inflight_q;
    assign busy      = (inflight_q != '0);

endmodule

// File: tb/tb_alu_op_scheduler.sv
// tb/tb_alu_op_scheduler.sv - directed self-checking bench for alu_op_scheduler
module tb_alu_op_scheduler;

    localparam int N  = 4;
    localparam int L  = 9;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          hold;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*DW-1:0] req_a, req_b, req_m;
    logic [N*2-1:0]  req_sel;
    logic [DW-1:0] alu_a, alu_b, alu_m, alu_out, rsp_data;
    logic [1:0]    alu_sel;
    logic          alu_issue, rsp_err, busy;
    logic [N-1:0]  rsp_valid;
    logic [3:0]    inflight;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_op_scheduler #(.NREQ(N), .LATENCY(L), .DW(DW)) dut (
        .clk(clk), .reset(reset), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_m(req_m), .req_sel(req_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_m(alu_m), .alu_sel(alu_sel),
        .alu_issue(alu_issue), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .inflight(inflight), .busy(busy)
    );

    // ALU model: add a+b, mul a*m, mac a*m+b, fixed L-cycle pipeline
    function automatic logic [7:0] alu_f(input logic [7:0] a, b, m, input logic [1:0] s);
        case (s)
            2'b01:   return 8'(a * m);
            2'b10:   return 8'(a * m + b);
            default: return 8'(a + b);
        endcase
    endfunction

    logic [7:0] mp [L];
    always @(posedge clk) begin
        mp[0] <= alu_issue ? alu_f(alu_a, alu_b, alu_m, alu_sel) : 8'hEE;
        for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
    end
    assign alu_out = mp[L-1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, b, m, input logic [1:0] s);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        req_m[i*8 +: 8] = m;
        req_sel[i*2 +: 2] = s;
    endtask

    task automatic do_reset();
        reset = 1'b1; hold = 1'b0; req_valid = '0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; hold = 1'b0; req_valid = '1;
        req_a = '1; req_b = '1; req_m = '1; req_sel = '0;
        step(); step();
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        checks++; if (alu_issue !== 1'b0) begin failures++; $display("FAIL reset_issue got=%b exp=0", alu_issue); end
        checks++; if ({alu_a, alu_b, alu_m} !== 24'h0) begin failures++; $display("FAIL reset_operands got=%h exp=000000", {alu_a, alu_b, alu_m}); end
        checks++; if (alu_sel !== 2'b00) begin failures++; $display("FAIL reset_sel got=%b exp=00", alu_sel); end
        checks++; if (rsp_valid !== 4'b0000 || rsp_err !== 1'b0 || rsp_data !== 8'h00) begin failures++; $display("FAIL reset_rsp got=%b/%b/%h exp=0000/0/00", rsp_valid, rsp_err, rsp_data); end
        checks++; if (inflight !== 4'd0 || busy !== 1'b0) begin failures++; $display("FAIL reset_inflight got=%0d/%b exp=0/0", inflight, busy); end
        req_valid = '0;
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        set_op(0, 8'h12, 8'h34, 8'h00, 2'b00);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
        step();
        req_valid = '0;
        #1;
        checks++; if (alu_issue !== 1'b1) begin failures++; $display("FAIL single_issue got=%b exp=1", alu_issue); end
        checks++; if (alu_a !== 8'h12 || alu_b !== 8'h34 || alu_sel !== 2'b00) begin failures++; $display("FAIL single_operands got=%h/%h/%b exp=12/34/00", alu_a, alu_b, alu_sel); end
        checks++; if (inflight !== 4'd1 || busy !== 1'b1) begin failures++; $display("FAIL single_inflight_issue got=%0d/%b exp=1/1", inflight, busy); end
        for (int k = 1; k <= L; k++) begin
            step();
            #1;
            if (k < L) begin
                checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL single_early_rsp k=%0d got=%b exp=0000", k, rsp_valid); end
                checks++; if (inflight !== 4'd1) begin failures++; $display("FAIL single_inflight k=%0d got=%0d exp=1", k, inflight); end
            end else begin
                checks++; if (rsp_valid !== 4'b0001 || rsp_data !== 8'h46 || rsp_err !== 1'b0) begin failures++; $display("FAIL single_rsp got=%b/%h/%b exp=0001/46/0", rsp_valid, rsp_data, rsp_err); end
                checks++; if (inflight !== 4'd0) begin failures++; $display("FAIL single_inflight_end got=%0d exp=0", inflight); end
            end
        end
    endtask

    task automatic test_fairness();
        logic [3:0] er, ev;
        logic [7:0] ed;
        int g, lo, hi, ei;
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 8'(8'h10 + i), 8'h01, 8'h00, 2'b00);
        for (int t = 0; t < 12 + L + 2; t++) begin
            if (t > 0) step();
            req_valid = (t < 12) ? 4'b1111 : 4'b0000;
            #1;
            er = (t < 12) ? 4'(1 << (t % 4)) : 4'b0000;
            checks++; if (req_ready !== er) begin failures++; $display("FAIL fair_ready t=%0d got=%b exp=%b", t, req_ready, er); end
            g = t - 1 - L;
            ev = (g >= 0 && g < 12) ? 4'(1 << (g % 4)) : 4'b0000;
            ed = (g >= 0 && g < 12) ? 8'(8'h11 + (g % 4)) : 8'h00;
            checks++; if (rsp_valid !== ev || rsp_data !== ed) begin failures++; $display("FAIL fair_rsp t=%0d got=%b/%h exp=%b/%h", t, rsp_valid, rsp_data, ev, ed); end
            lo = (t - L > 0) ? t - L : 0;
            hi = (t - 1 < 11) ? t - 1 : 11;
            ei = (hi >= lo) ? hi - lo + 1 : 0;
            checks++; if (inflight !== 4'(ei)) begin failures++; $display("FAIL fair_inflight t=%0d got=%0d exp=%0d", t, inflight, ei); end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        set_op(2, 8'h05, 8'h06, 8'h07, 2'b11);
        for (int t = 0; t <= L + 2; t++) begin
            if (t > 0) step();
            req_valid = (t == 0) ? 4'b0100 : 4'b0000;
            #1;
            if (t == 0) begin
                checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL illegal_ready got=%b exp=0100", req_ready); end
            end
            if (t == 1) begin
                checks++; if (alu_issue !== 1'b1 || alu_sel !== 2'b00 || alu_a !== 8'h05) begin failures++; $display("FAIL illegal_issue got=%b/%b/%h exp=1/00/05", alu_issue, alu_sel, alu_a); end
            end
            if (t == L + 1) begin
                checks++; if (rsp_valid !== 4'b0100 || rsp_err !== 1'b1 || rsp_data !== 8'h00) begin failures++; $display("FAIL illegal_rsp got=%b/%b/%h exp=0100/1/00", rsp_valid, rsp_err, rsp_data); end
            end else begin
                checks++; if (rsp_valid !== 4'b0000 || rsp_err !== 1'b0) begin failures++; $display("FAIL illegal_idle t=%0d got=%b/%b exp=0000/0", t, rsp_valid, rsp_err); end
            end
        end
    endtask

    task automatic test_hold();
        logic [3:0] er, ev;
        logic [7:0] ed;
        do_reset();
        set_op(0, 8'h01, 8'h02, 8'h00, 2'b00);
        set_op(1, 8'h03, 8'h04, 8'h00, 2'b00);
        for (int t = 0; t < 18; t++) begin
            if (t > 0) step();
            req_valid = (t == 0) ? 4'b0001 : (t <= 6) ? 4'b0010 : 4'b0000;
            hold = (t >= 1 && t <= 5);
            #1;
            er = (t == 0) ? 4'b0001 : (t == 6) ? 4'b0010 : 4'b0000;
            checks++; if (req_ready !== er) begin failures++; $display("FAIL hold_ready t=%0d got=%b exp=%b", t, req_ready, er); end
            ev = (t == 10) ? 4'b0001 : (t == 16) ? 4'b0010 : 4'b0000;
            ed = (t == 10) ? 8'h03 : (t == 16) ? 8'h07 : 8'h00;
            checks++; if (rsp_valid !== ev || rsp_data !== ed) begin failures++; $display("FAIL hold_rsp t=%0d got=%b/%h exp=%b/%h", t, rsp_valid, rsp_data, ev, ed); end
        end
        hold = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) set_op(i, 8'(i + 1), 8'h10, 8'h00, 2'b00);
        for (int t = 0; t < 3; t++) begin
            if (t > 0) step();
            req_valid = 4'b0111;
            #1;
            checks++; if (req_ready !== 4'(1 << t)) begin failures++; $display("FAIL rstmid_ready t=%0d got=%b exp=%b", t, req_ready, 4'(1 << t)); end
        end
        step();
        req_valid = '0;
        reset = 1'b1;
        #1;
        checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL rstmid_rsp_in_reset got=%b exp=0000", rsp_valid); end
        step();
        reset = 1'b0;
        #1;
        checks++; if (inflight !== 4'd0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_inflight got=%0d/%b exp=0/0", inflight, busy); end
        for (int t = 0; t < 2 * L; t++) begin
            checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL rstmid_rsp t=%0d got=%b exp=0000", t, rsp_valid); end
            step();
        end
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rstmid_next_grant got=%b exp=0001", req_ready); end
        step();
        req_valid = '0;
    endtask

    task automatic test_back_to_back();
        int ei;
        do_reset();
        set_op(3, 8'h03, 8'h00, 8'h05, 2'b01);
        for (int t = 0; t < 2 * L + 5; t++) begin
            if (t > 0) step();
            req_valid = 4'b1000;
            #1;
            checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL b2b_ready t=%0d got=%b exp=1000", t, req_ready); end
            ei = (t < L) ? t : L;
            checks++; if (inflight !== 4'(ei)) begin failures++; $display("FAIL b2b_inflight t=%0d got=%0d exp=%0d", t, inflight, ei); end
            if (t >= 1) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy t=%0d got=%b exp=1", t, busy); end
            end
            if (t >= L + 1) begin
                checks++; if (rsp_valid !== 4'b1000 || rsp_data !== 8'h0F) begin failures++; $display("FAIL b2b_rsp t=%0d got=%b/%h exp=1000/0f", t, rsp_valid, rsp_data); end
            end else begin
                checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL b2b_idle t=%0d got=%b exp=0000", t, rsp_valid); end
            end
        end
        step();
        req_valid = '0;
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0; req_valid = '0;
        req_a = '0; req_b = '0; req_m = '0; req_sel = '0;
        test_reset();
        test_single();
        test_fairness();
        test_illegal();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
